counter_stim_sequencer: RTL and testbench

Command-driven initiator for the 8-bit loadable up/down counter. It accepts LOAD/UP/DOWN/HOLD commands through a valid/ready port and buffers them in a small FIFO. Each command is expanded into cycle-accurate `ld_cnt_`, `updn_cnt`, `count_enb` and `data_in` drive on the counter's control pins. A reference model `exp_data` tracks what the counter's `data_out` must read, for use by scoreboards and property checkers in the counter bench.

---
 rtl/counter_pkg.sv | 35 +++
 rtl/cmd_fifo.sv | 59 +++++
 rtl/counter_stim_sequencer.sv | 122 ++++++++++++
 tb/tb_counter_stim_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types, widths and the counter reference rule
package counter_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_LOAD = 2'b01,
        CMD_UP   = 2'b10,
        CMD_DOWN = 2'b11
    } cmd_op_e;

    typedef struct packed {
        cmd_op_e          op;
        logic [3:0]       len;
        logic [CNT_W-1:0] data;
    } cmd_t;

    // Next data_out of the loadable up/down counter given the pins it saw last cycle.
    function automatic logic [CNT_W-1:0] cnt_next(
        input logic [CNT_W-1:0] cur,
        input logic             ld_n,
        input logic             enb,
        input logic             updn,
        input logic [CNT_W-1:0] din
    );
        if (!ld_n) begin
            return din;
        end else if (enb) begin
            return updn ? cur + 8'd1 : cur - 8'd1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - DEPTH-entry command FIFO with extra-bit wrap pointers
module cmd_fifo
    import counter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        do_push;
    logic        do_pop;
    cmd_t        mem_q [DEPTH];

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) begin
            wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_d = rd_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/counter_stim_sequencer.sv
// rtl/counter_stim_sequencer.sv - expands queued commands into counter pin drive plus expected data_out
module counter_stim_sequencer
    import counter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  cmd_op_e          cmd_op,
    input  logic [3:0]       cmd_len,
    input  logic [CNT_W-1:0] cmd_data,
    output logic             ld_cnt_,
    output logic             updn_cnt,
    output logic             count_enb,
    output logic [CNT_W-1:0] data_in,
    output logic [CNT_W-1:0] exp_data,
    output logic             busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [3:0]       rem_q, rem_d;
    logic             ld_q, ld_d;
    logic             up_q, up_d;
    logic             en_q, en_d;
    logic [CNT_W-1:0] din_q, din_d;
    logic [CNT_W-1:0] exp_q, exp_d;

    cmd_t head;
    cmd_t push_cmd;
    logic fifo_full;
    logic fifo_empty;
    logic pop;

    assign push_cmd = '{op: cmd_op, len: cmd_len, data: cmd_data};

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_      (rst_),
        .push      (cmd_valid),
        .push_data (push_cmd),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ld_d    = ld_q;
        up_d    = up_q;
        en_d    = en_q;
        din_d   = din_q;
        pop     = 1'b0;
        if (state_q == ST_ISSUE && rem_q != 4'd0) begin
            rem_d = rem_q - 4'd1;
        end else if (!fifo_empty) begin
            // Popping straight from the last cycle of a command keeps commands abutted.
            pop     = 1'b1;
            state_d = ST_ISSUE;
            rem_d   = head.len;
            ld_d    = 1'b1;
            up_d    = 1'b0;
            en_d    = 1'b0;
            din_d   = '0;
            case (head.op)
                CMD_LOAD: begin
                    ld_d  = 1'b0;
                    din_d = head.data;
                end
                CMD_UP: begin
                    en_d = 1'b1;
                    up_d = 1'b1;
                end
                CMD_DOWN: en_d = 1'b1;
                default: ;
            endcase
        end else begin
            state_d = ST_IDLE;
            rem_d   = 4'd0;
            ld_d    = 1'b1;
            up_d    = 1'b0;
            en_d    = 1'b0;
            din_d   = '0;
        end
        exp_d = cnt_next(exp_q, ld_q, en_q, up_q, din_q);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            rem_q   <= 4'd0;
            ld_q    <= 1'b1;
            up_q    <= 1'b0;
            en_q    <= 1'b0;
            din_q   <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ld_q    <= ld_d;
            up_q    <= up_d;
            en_q    <= en_d;
            din_q   <= din_d;
            exp_q   <= exp_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign ld_cnt_   = ld_q;
    assign updn_cnt  = up_q;
    assign count_enb = en_q;
    assign data_in   = din_q;
    assign exp_data  = exp_q;
    assign busy      = (state_q == ST_ISSUE) || !fifo_empty;

endmodule

// File: tb/tb_counter_stim_sequencer.sv
// tb/tb_counter_stim_sequencer.sv - directed vector bench for counter_stim_sequencer
module tb_counter_stim_sequencer;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    cmd_op_e    cmd_op = CMD_HOLD;
    logic [3:0] cmd_len = 4'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       ld_cnt_;
    logic       updn_cnt;
    logic       count_enb;
    logic [7:0] data_in;
    logic [7:0] exp_data;
    logic       busy;

    int total = 0;
    int bad = 0;

    counter_stim_sequencer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .ld_cnt_   (ld_cnt_),
        .updn_cnt  (updn_cnt),
        .count_enb (count_enb),
        .data_in   (data_in),
        .exp_data  (exp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        cmd_op_e    op;
        logic [3:0] len;
        logic [7:0] data;
        logic       e_ld;
        logic       e_up;
        logic       e_en;
        logic [7:0] e_din;
        logic [7:0] e_first;
        logic [7:0] e_last;
    } vec_t;

    typedef struct {
        cmd_op_e    op;
        logic [3:0] len;
        logic [7:0] data;
    } cmd_rec_t;

    typedef struct {
        logic       ld;
        logic       up;
        logic       en;
        logic [7:0] din;
    } ctrl_t;

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", nm, act, req);
        end
    endtask

    task automatic chk_ctrl(input string nm, input ctrl_t c);
        chk1({nm, ".ld_cnt_"}, ld_cnt_, c.ld);
        chk1({nm, ".updn_cnt"}, updn_cnt, c.up);
        chk1({nm, ".count_enb"}, count_enb, c.en);
        chk8({nm, ".data_in"}, data_in, c.din);
    endtask

    function automatic ctrl_t expand(input cmd_op_e op, input logic [7:0] d);
        ctrl_t c;
        c = '{ld: 1'b1, up: 1'b0, en: 1'b0, din: 8'h00};
        case (op)
            CMD_LOAD: begin c.ld = 1'b0; c.din = d; end
            CMD_UP:   begin c.en = 1'b1; c.up = 1'b1; end
            CMD_DOWN: c.en = 1'b1;
            default:  ;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] model_next(input logic [7:0] cur, input ctrl_t c);
        if (!c.ld) return c.din;
        if (c.en) return c.up ? cur + 8'd1 : cur - 8'd1;
        return cur;
    endfunction

    vec_t     vecs [10];
    cmd_rec_t cmds [5];
    cmd_rec_t rcmds [3];
    ctrl_t    stream [$];
    ctrl_t    hold_c;
    ctrl_t    cur_c;
    ctrl_t    prev_c;
    logic [7:0] m_exp;

    initial begin
        hold_c = '{ld: 1'b1, up: 1'b0, en: 1'b0, din: 8'h00};

        vecs[0] = '{CMD_LOAD, 4'd0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h5A, 8'h5A};
        vecs[1] = '{CMD_UP,   4'd2, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h5B, 8'h5D};
        vecs[2] = '{CMD_LOAD, 4'd0, 8'hFE, 1'b0, 1'b0, 1'b0, 8'hFE, 8'hFE, 8'hFE};
        vecs[3] = '{CMD_UP,   4'd2, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h01};
        vecs[4] = '{CMD_LOAD, 4'd0, 8'h01, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 8'h01};
        vecs[5] = '{CMD_DOWN, 4'd2, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFE};
        vecs[6] = '{CMD_LOAD, 4'd0, 8'h33, 1'b0, 1'b0, 1'b0, 8'h33, 8'h33, 8'h33};
        vecs[7] = '{CMD_HOLD, 4'd3, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 8'h33, 8'h33};
        vecs[8] = '{CMD_LOAD, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[9] = '{CMD_DOWN, 4'd0, 8'h55, 1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 8'hFF};

        cmds[0] = '{CMD_UP,   4'd15, 8'h00};
        cmds[1] = '{CMD_LOAD, 4'd0,  8'h80};
        cmds[2] = '{CMD_DOWN, 4'd1,  8'h00};
        cmds[3] = '{CMD_HOLD, 4'd0,  8'hC3};
        cmds[4] = '{CMD_UP,   4'd2,  8'h00};

        rcmds[0] = '{CMD_UP,   4'd9, 8'h00};
        rcmds[1] = '{CMD_LOAD, 4'd0, 8'hAA};
        rcmds[2] = '{CMD_DOWN, 4'd1, 8'h00};

        // Reset state while rst_ is held low
        #12;
        chk_ctrl("reset", hold_c);
        chk8("reset.exp_data", exp_data, 8'h00);
        chk1("reset.busy", busy, 1'b0);
        chk1("reset.cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1;

        // Table: each command pushed into an idle sequencer
        for (int v = 0; v < 10; v++) begin
            chk1($sformatf("v%0d.ready", v), cmd_ready, 1'b1);
            cmd_valid = 1'b1;
            cmd_op    = vecs[v].op;
            cmd_len   = vecs[v].len;
            cmd_data  = vecs[v].data;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            @(posedge clk);
            #1;
            for (int k = 0; k <= int'(vecs[v].len); k++) begin
                cur_c = '{ld: vecs[v].e_ld, up: vecs[v].e_up, en: vecs[v].e_en, din: vecs[v].e_din};
                chk_ctrl($sformatf("v%0d.c%0d", v, k), cur_c);
                @(posedge clk);
                #1;
                if (k == 0) chk8($sformatf("v%0d.exp_first", v), exp_data, vecs[v].e_first);
                if (k == int'(vecs[v].len)) chk8($sformatf("v%0d.exp_last", v), exp_data, vecs[v].e_last);
            end
            chk_ctrl($sformatf("v%0d.after", v), hold_c);
            chk1($sformatf("v%0d.idle_busy", v), busy, 1'b0);
        end

        // Back-to-back pushes behind a long first command: FIFO fills, order and abutment kept
        stream.delete();
        foreach (cmds[i]) begin
            for (int r = 0; r <= int'(cmds[i].len); r++) stream.push_back(expand(cmds[i].op, cmds[i].data));
        end
        m_exp  = 8'hFF;
        prev_c = hold_c;
        for (int cyc = 0; cyc < 26; cyc++) begin
            if (cyc < 5) begin
                cmd_valid = 1'b1;
                cmd_op    = cmds[cyc].op;
                cmd_len   = cmds[cyc].len;
                cmd_data  = cmds[cyc].data;
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cur_c = (cyc >= 1 && cyc - 1 < stream.size()) ? stream[cyc-1] : hold_c;
            m_exp = model_next(m_exp, prev_c);
            chk_ctrl($sformatf("fill.c%0d", cyc), cur_c);
            chk8($sformatf("fill.exp%0d", cyc), exp_data, m_exp);
            chk1($sformatf("fill.ready%0d", cyc), cmd_ready, !(cyc >= 4 && cyc <= 16));
            prev_c = cur_c;
        end
        chk1("fill.end_busy", busy, 1'b0);
        chk8("fill.end_exp", exp_data, 8'h81);

        // Reset mid-UP with two commands still queued
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = rcmds[i].op;
            cmd_len   = rcmds[i].len;
            cmd_data  = rcmds[i].data;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk1("mid.count_enb", count_enb, 1'b1);
        chk1("mid.busy", busy, 1'b1);
        rst_ = 1'b0;
        #1;
        chk_ctrl("rst_async", hold_c);
        chk8("rst_async.exp_data", exp_data, 8'h00);
        chk1("rst_async.busy", busy, 1'b0);
        chk1("rst_async.ready", cmd_ready, 1'b1);
        @(negedge clk);
        rst_ = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk);
            #1;
            chk_ctrl($sformatf("post_rst.c%0d", cyc), hold_c);
            chk8($sformatf("post_rst.exp%0d", cyc), exp_data, 8'h00);
            chk1($sformatf("post_rst.busy%0d", cyc), busy, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
